// File: rtl/mem_drv_1r1w.sv
// Self-checking 1R1W memory traffic initiator: fill, byte-masked overwrite, readback with compare.
// Requests registered; compares LATENCY cycles after each read; no backpressure, start ignored while busy.
module mem_drv_1r1w #(
    parameter int unsigned AW      = 10,
    parameter int unsigned DW      = 32,
    parameter int unsigned WORDS   = 1024,
    parameter int unsigned LATENCY = 2,
    parameter logic [31:0] SEED    = 32'hA5A5_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [15:0]   err_cnt,
    output logic [AW-1:0] first_err_addr,
    output logic          read_0,
    output logic [AW-1:0] addr_0,
    input  logic [DW-1:0] dout_0,
    input  logic          read_serr_0,
    input  logic          read_derr_0,
    output logic          write_1,
    output logic [AW-1:0] addr_1,
    output logic [DW-1:0] bw_1,
    output logic [DW-1:0] din_1
);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_MASK, S_CHECK, S_DRAIN, S_DONE} state_t;

    localparam logic [AW:0] ONE   = (AW+1)'(1);
    localparam logic [AW:0] LAST  = (AW+1)'(WORDS - 1);
    localparam logic [AW:0] WEND  = (AW+1)'(WORDS);
    localparam logic [4:0]  DLAST = 5'(LATENCY > 0 ? LATENCY - 1 : 0);

    function automatic logic [DW-1:0] odd_bits();
        logic [DW-1:0] m;
        m = '0;
        for (int i = 1; i < DW; i += 2) m[i] = 1'b1;
        return m;
    endfunction

    localparam logic [DW-1:0] MPAT = odd_bits();

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        logic [31:0]   s;
        logic [DW-1:0] p;
        s = SEED ^ 32'(a);
        for (int i = 0; i < DW; i++) p[i] = s[i % 32];
        return p;
    endfunction

    state_t        state, nxt_state;
    logic [AW:0]   c, nxt_c;
    logic [4:0]    dc, nxt_dc;
    logic          start_acc;
    logic          rd_n, wr_n, busy_n;
    logic [AW-1:0] ra_n, wa_n;
    logic [DW-1:0] exp_n, din_n, bw_n;
    logic [DW-1:0] exp_q;
    logic          cmp_vld, cmp_err;
    logic [AW-1:0] cmp_addr;
    logic [DW-1:0] cmp_exp;
    logic [15:0]   err_upd;
    logic          unused_serr;

    assign unused_serr = read_serr_0;
    assign start_acc   = start && (state == S_IDLE || state == S_DONE);

    always_comb begin
        nxt_state = state;
        nxt_c     = c;
        nxt_dc    = dc;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    nxt_state = S_FILL;
                    nxt_c     = '0;
                end
            end
            S_FILL: begin
                if (c == LAST) begin
                    nxt_state = S_MASK;
                    nxt_c     = '0;
                end else begin
                    nxt_c = c + ONE;
                end
            end
            S_MASK: begin
                if (c == WEND) begin
                    nxt_state = S_CHECK;
                    nxt_c     = '0;
                end else begin
                    nxt_c = c + ONE;
                end
            end
            S_CHECK: begin
                if (c == LAST) begin
                    nxt_c     = '0;
                    nxt_dc    = '0;
                    nxt_state = (LATENCY == 0) ? S_DONE : S_DRAIN;
                end else begin
                    nxt_c = c + ONE;
                end
            end
            S_DRAIN: begin
                if (dc == DLAST) nxt_state = S_DONE;
                else             nxt_dc = dc + 5'd1;
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so requests line up with state entry.
    always_comb begin
        busy_n = nxt_state inside {S_FILL, S_MASK, S_CHECK, S_DRAIN};
        rd_n   = (nxt_state == S_MASK && nxt_c != WEND) || nxt_state == S_CHECK;
        wr_n   = nxt_state == S_FILL || (nxt_state == S_MASK && nxt_c != '0);
        ra_n   = nxt_c[AW-1:0];
        wa_n   = (nxt_state == S_MASK) ? nxt_c[AW-1:0] - AW'(1) : nxt_c[AW-1:0];
        exp_n  = (nxt_state == S_CHECK) ? pat(ra_n) ^ MPAT : pat(ra_n);
        din_n  = (nxt_state == S_MASK) ? ~pat(wa_n) : pat(wa_n);
        bw_n   = (nxt_state == S_MASK) ? MPAT : '1;
    end

    generate
        if (LATENCY == 0) begin : g_comb
            assign cmp_vld  = read_0;
            assign cmp_addr = addr_0;
            assign cmp_exp  = exp_q;
        end else begin : g_pipe
            logic [LATENCY-1:0] pv;
            logic [AW-1:0]      pa [LATENCY];
            logic [DW-1:0]      pe [LATENCY];

            always_ff @(posedge clk) begin
                if (!rst) begin
                    pv <= '0;
                end else begin
                    pv[0] <= read_0;
                    for (int k = 1; k < LATENCY; k++) pv[k] <= pv[k-1];
                end
            end

            always_ff @(posedge clk) begin
                pa[0] <= addr_0;
                pe[0] <= exp_q;
                for (int k = 1; k < LATENCY; k++) begin
                    pa[k] <= pa[k-1];
                    pe[k] <= pe[k-1];
                end
            end

            assign cmp_vld  = pv[LATENCY-1];
            assign cmp_addr = pa[LATENCY-1];
            assign cmp_exp  = pe[LATENCY-1];
        end
    endgenerate

    assign cmp_err = cmp_vld && ((dout_0 != cmp_exp) || read_derr_0);
    assign err_upd = !cmp_err ? err_cnt :
                     (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_IDLE;
            c              <= '0;
            dc             <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            read_0         <= 1'b0;
            addr_0         <= '0;
            exp_q          <= '0;
            write_1        <= 1'b0;
            addr_1         <= '0;
            bw_1           <= '0;
            din_1          <= '0;
        end else begin
            state   <= nxt_state;
            c       <= nxt_c;
            dc      <= nxt_dc;
            busy    <= busy_n;
            read_0  <= rd_n;
            addr_0  <= rd_n ? ra_n : '0;
            exp_q   <= rd_n ? exp_n : '0;
            write_1 <= wr_n;
            addr_1  <= wr_n ? wa_n : '0;
            bw_1    <= wr_n ? bw_n : '0;
            din_1   <= wr_n ? din_n : '0;
            if (start_acc) begin
                err_cnt        <= '0;
                first_err_addr <= '0;
                done           <= 1'b0;
                pass           <= 1'b0;
            end else begin
                err_cnt <= err_upd;
                if (cmp_err && err_cnt == '0) first_err_addr <= cmp_addr;
                // The final return is compared on the same edge that enters DONE.
                if (nxt_state == S_DONE && state != S_DONE) begin
                    done <= 1'b1;
                    pass <= (err_upd == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_drv_1r1w.sv
// Bench for mem_drv_1r1w: ideal 1R1W memories (latency 2 and 0) with injectable read faults and a scoreboard.
module tb_mem_drv_1r1w;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int W  = 16;
    localparam logic [31:0] SEED = 32'hA5A5_0000;
    localparam logic [31:0] M    = 32'hAAAA_AAAA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, start0;

    logic          busy, done, pass, rd, wr, serr, derr;
    logic [15:0]   ecnt;
    logic [AW-1:0] fea, ra, wa;
    logic [DW-1:0] dout, bw, din;

    logic          busy0, done0, pass0, rd0, wr0, serr0, derr0;
    logic [15:0]   ecnt0;
    logic [AW-1:0] fea0, ra0, wa0;
    logic [DW-1:0] dout0, bw0, din0;

    mem_drv_1r1w #(.AW(AW), .DW(DW), .WORDS(W), .LATENCY(2), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_cnt(ecnt), .first_err_addr(fea), .read_0(rd), .addr_0(ra), .dout_0(dout),
        .read_serr_0(serr), .read_derr_0(derr), .write_1(wr), .addr_1(wa), .bw_1(bw), .din_1(din)
    );

    mem_drv_1r1w #(.AW(AW), .DW(DW), .WORDS(W), .LATENCY(0), .SEED(SEED)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(ecnt0), .first_err_addr(fea0), .read_0(rd0), .addr_0(ra0), .dout_0(dout0),
        .read_serr_0(serr0), .read_derr_0(derr0), .write_1(wr0), .addr_1(wa0), .bw_1(bw0), .din_1(din0)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] P(input int a);
        return SEED ^ 32'(a);
    endfunction

    // Fault plan indexed by read number within a run: reads 0..W-1 are the mask pass, W..2W-1 the check pass.
    logic [31:0] flip  [2*W];
    bit          dfl   [2*W];
    logic [31:0] flip0 [2*W];
    bit          dfl0  [2*W];

    // Ideal memory, read latency 2.
    logic [31:0] mem [W];
    logic [31:0] rq_d [2];
    logic        rq_e [2];
    int kc = 0;
    int k_base = 0;
    int idx;

    always @(posedge clk) begin
        idx = kc - k_base;
        serr <= 1'($urandom);
        if (rd) begin
            rq_d[0] <= mem[ra] ^ ((idx >= 0 && idx < 2*W) ? flip[idx] : 32'd0);
            rq_e[0] <= (idx >= 0 && idx < 2*W) && dfl[idx];
            kc <= kc + 1;
        end else begin
            rq_d[0] <= 32'd0;
            rq_e[0] <= 1'b0;
        end
        rq_d[1] <= rq_d[0];
        rq_e[1] <= rq_e[0];
        if (wr) mem[wa] <= (mem[wa] & ~bw) | (din & bw);
    end
    assign dout = rq_d[1];
    assign derr = rq_e[1];

    // Ideal memory with combinational read.
    logic [31:0] mem0 [W];
    int kc0 = 0;
    int k0_base = 0;
    logic [31:0] f0;
    logic        e0;

    always @(posedge clk) begin
        serr0 <= 1'($urandom);
        if (rd0) kc0 <= kc0 + 1;
        if (wr0) mem0[wa0] <= (mem0[wa0] & ~bw0) | (din0 & bw0);
    end
    always_comb begin
        f0 = 32'd0;
        e0 = 1'b0;
        if (rd0 && (kc0 - k0_base) >= 0 && (kc0 - k0_base) < 2*W) begin
            f0 = flip0[kc0 - k0_base];
            e0 = dfl0[kc0 - k0_base];
        end
    end
    assign dout0 = mem0[ra0] ^ f0;
    assign derr0 = e0;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] m; logic [DW-1:0] d; } wr_t;
    typedef struct { int bc; int ne; logic [AW-1:0] fa; logic ps; } res_t;
    wr_t           wq [$];
    logic [AW-1:0] rq [$];
    res_t          eq [$];
    res_t          eq0 [$];
    int exp_done = 0;

    // Scoreboard monitor for the latency-2 driver.
    int   bcnt = 0;
    int   ndone = 0;
    logic dprev = 1'b0;
    wr_t  wm;
    res_t rm;
    logic [AW-1:0] am;

    always @(negedge clk) begin
        if (!rst) begin
            bcnt  = 0;
            dprev = 1'b0;
        end else begin
            if (busy) bcnt++;
            if (wr) begin
                if (wq.size() == 0) chk("spurious write", 64'(wq.size()), 64'd1);
                else begin
                    wm = wq.pop_front();
                    chk("write addr", 64'(wa), 64'(wm.a));
                    chk("write mask", 64'(bw), 64'(wm.m));
                    chk("write data", 64'(din), 64'(wm.d));
                end
            end
            if (rd) begin
                if (rq.size() == 0) chk("spurious read", 64'(rq.size()), 64'd1);
                else begin
                    am = rq.pop_front();
                    chk("read addr", 64'(ra), 64'(am));
                end
            end
            if (done && !dprev) begin
                ndone++;
                if (eq.size() == 0) chk("spurious done", 64'(eq.size()), 64'd1);
                else begin
                    rm = eq.pop_front();
                    chk("busy cycles", 64'(bcnt), 64'(rm.bc));
                    chk("err_cnt", 64'(ecnt), 64'(rm.ne));
                    chk("first_err_addr", 64'(fea), 64'(rm.fa));
                    chk("pass", 64'(pass), 64'(rm.ps));
                end
                bcnt = 0;
            end
            dprev = done;
        end
    end

    // Monitor for the latency-0 driver.
    int   bcnt0 = 0;
    int   ndone0 = 0;
    logic dprev0 = 1'b0;
    logic pend0 = 1'b0;
    int   perr0 = 0;
    res_t rm0;

    always @(negedge clk) begin
        if (!rst) begin
            bcnt0  = 0;
            dprev0 = 1'b0;
            pend0  = 1'b0;
        end else begin
            if (busy0) bcnt0++;
            if (pend0) begin
                chk("L0 same-cycle compare", 64'(ecnt0), 64'(perr0 + 1));
                pend0 = 1'b0;
            end
            if (rd0 && (f0 != 32'd0 || e0)) begin
                pend0 = 1'b1;
                perr0 = int'(ecnt0);
            end
            if (done0 && !dprev0) begin
                ndone0++;
                if (eq0.size() == 0) chk("L0 spurious done", 64'(eq0.size()), 64'd1);
                else begin
                    rm0 = eq0.pop_front();
                    chk("L0 busy cycles", 64'(bcnt0), 64'(rm0.bc));
                    chk("L0 err_cnt", 64'(ecnt0), 64'(rm0.ne));
                    chk("L0 first_err_addr", 64'(fea0), 64'(rm0.fa));
                    chk("L0 pass", 64'(pass0), 64'(rm0.ps));
                end
                bcnt0 = 0;
            end
            dprev0 = done0;
        end
    end

    task automatic clear_faults();
        for (int k = 0; k < 2*W; k++) begin
            flip[k]  = 32'd0;
            dfl[k]   = 1'b0;
            flip0[k] = 32'd0;
            dfl0[k]  = 1'b0;
        end
    endtask

    task automatic push_reqs();
        for (int a = 0; a < W; a++) wq.push_back('{4'(a), 32'hFFFF_FFFF, P(a)});
        for (int a = 0; a < W; a++) wq.push_back('{4'(a), M, ~P(a)});
        for (int a = 0; a < W; a++) rq.push_back(4'(a));
        for (int a = 0; a < W; a++) rq.push_back(4'(a));
    endtask

    // Every faulted read is one error; the first error is the earliest faulted read in issue order.
    task automatic push_result(input bit l0, input int bc);
        int ne;
        logic [AW-1:0] fa;
        ne = 0;
        fa = '0;
        for (int k = 0; k < 2*W; k++) begin
            if (l0 ? (flip0[k] != 0 || dfl0[k]) : (flip[k] != 0 || dfl[k])) begin
                if (ne == 0) fa = 4'(k % W);
                ne++;
            end
        end
        if (l0) eq0.push_back('{bc, ne, fa, ne == 0});
        else    eq.push_back('{bc, ne, fa, ne == 0});
        exp_done++;
    endtask

    task automatic pulse(input bit l0);
        @(posedge clk); #1;
        if (l0) start0 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        start0 = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((eq.size() != 0 || eq0.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk({name, " completion"}, 64'(eq.size() + eq0.size()), 64'd0);
        chk({name, " leftover writes"}, 64'(wq.size()), 64'd0);
        chk({name, " leftover reads"}, 64'(rq.size()), 64'd0);
        eq.delete(); eq0.delete(); wq.delete(); rq.delete();
        @(posedge clk); #1;
    endtask

    task automatic run_l2(input string name, input bit extra_start);
        k_base = kc;
        push_reqs();
        push_result(1'b0, 3*W + 1 + 2);
        pulse(1'b0);
        chk({name, " busy after start"}, 64'(busy), 64'd1);
        chk({name, " err cleared"}, 64'(ecnt), 64'd0);
        chk({name, " done cleared"}, 64'(done), 64'd0);
        if (extra_start) begin
            repeat (4) @(posedge clk);
            #1;
            chk("second start at fill addr 4", 64'(wa), 64'd4);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        wait_idle(name);
    endtask

    task automatic run_l0(input string name);
        k0_base = kc0;
        push_result(1'b1, 3*W + 1);
        pulse(1'b1);
        wait_idle(name);
    endtask

    task automatic random_faults(input bit l0, input int density);
        clear_faults();
        for (int k = 0; k < 2*W; k++) begin
            int v;
            v = int'($urandom_range(0, density));
            if (v == 0 || v == 2) begin
                if (l0) flip0[k] = 32'd1 << $urandom_range(0, 31);
                else    flip[k]  = 32'd1 << $urandom_range(0, 31);
            end
            if (v == 1 || v == 2) begin
                if (l0) dfl0[k] = 1'b1;
                else    dfl[k]  = 1'b1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        start = 1'b0;
        start0 = 1'b0;
        clear_faults();
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset pass", 64'(pass), 64'd0);
        chk("reset err_cnt", 64'(ecnt), 64'd0);
        chk("reset first_err_addr", 64'(fea), 64'd0);
        chk("reset read_0", 64'(rd), 64'd0);
        chk("reset write_1", 64'(wr), 64'd0);
        chk("reset addr_0", 64'(ra), 64'd0);
        chk("reset addr_1", 64'(wa), 64'd0);
        chk("reset bw_1", 64'(bw), 64'd0);
        chk("reset din_1", 64'(din), 64'd0);
        chk("reset L0 busy", 64'(busy0), 64'd0);
        chk("reset L0 err_cnt", 64'(ecnt0), 64'd0);
        rst = 1'b1;

        clear_faults();
        run_l2("clean run", 1'b0);
        // Memory after the mask pass holds P(a)^M; addr 3 gives 32'h0F0F_AAA9.
        chk("mem addr 3 after run", 64'(mem[3]), 64'h0F0F_AAA9);

        clear_faults();
        flip[W + 5] = 32'd1;
        run_l2("check flip addr 5", 1'b0);

        clear_faults();
        dfl[2] = 1'b1;
        dfl[9] = 1'b1;
        run_l2("mask derr addr 2 and 9", 1'b0);

        for (int r = 0; r < 3; r++) begin
            random_faults(1'b0, 9);
            run_l2("random faults", 1'b0);
        end

        clear_faults();
        run_l2("start while busy", 1'b1);

        // Abort at MASK c=7 with faulted reads still in flight.
        clear_faults();
        dfl[5] = 1'b1;
        dfl[6] = 1'b1;
        dfl[7] = 1'b1;
        flip[6] = 32'd1;
        k_base = kc;
        push_reqs();
        pulse(1'b0);
        repeat (23) @(posedge clk);
        #1;
        chk("abort point read addr", 64'(ra), 64'd7);
        chk("abort point write addr", 64'(wa), 64'd6);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort read_0", 64'(rd), 64'd0);
        chk("abort write_1", 64'(wr), 64'd0);
        chk("abort err_cnt", 64'(ecnt), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        wq.delete();
        rq.delete();
        repeat (6) @(posedge clk);
        #1;
        chk("no late miscompare", 64'(ecnt), 64'd0);
        chk("no done after abort", 64'(done), 64'd0);

        clear_faults();
        run_l2("run after reset", 1'b0);

        clear_faults();
        run_l0("L0 clean");
        for (int r = 0; r < 2; r++) begin
            clear_faults();
            flip0[$urandom_range(0, 2*W - 1)] = 32'd1 << $urandom_range(0, 31);
            run_l0("L0 single fault");
        end
        random_faults(1'b1, 7);
        run_l0("L0 random faults");

        repeat (20) @(posedge clk);
        #1;
        chk("done count", 64'(ndone + ndone0), 64'(exp_done));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
